// File: rtl/window_allocator.sv
// Window allocator: collects the broadcast pixels that fall inside one
// filter window and accumulates their dot product with the filter weights.
module window_allocator #(
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              target_x,
  input  logic [7:0]              target_y,
  input  logic [1:0]              image_padding,
  input  logic [8:0]              z_max,
  input  logic                    issue_en,
  input  logic [7:0]              issue_x,
  input  logic [7:0]              issue_y,
  input  logic signed [17:0]      issue_data,
  output logic [11:0]             weight_addr,
  input  logic signed [17:0]      weight_data,
  output logic                    alloc_block,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_tx;
  logic [7:0]              r_ty;
  logic [1:0]              r_p;
  logic [14:0]             r_last;
  logic [14:0]             r_tap;
  logic signed [17:0]      r_px;
  logic                    r_v1;
  logic                    r_v2;
  logic signed [35:0]      r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_valid;
  logic                    r_block;
  logic                    r_ovf;

  logic [8:0]  w_ix;
  logic [8:0]  w_iy;
  logic [8:0]  w_tx;
  logic [8:0]  w_ty;
  logic [8:0]  w_p;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_match;
  logic        w_take;
  logic        w_busy;
  logic        w_load;
  logic [5:0]  w_kk;
  logic [14:0] w_last;

  // Window bounds compared at 9 bits so target-P never wraps below zero.
  assign w_ix   = {1'b0, issue_x};
  assign w_iy   = {1'b0, issue_y};
  assign w_tx   = {1'b0, r_tx};
  assign w_ty   = {1'b0, r_ty};
  assign w_p    = {7'b0, r_p};
  assign w_in_x = (w_ix + w_p >= w_tx) && (w_ix <= w_tx + w_p);
  assign w_in_y = (w_iy + w_p >= w_ty) && (w_iy <= w_ty + w_p);

  assign w_match = issue_en && w_in_x && w_in_y;
  assign w_take  = (r_state == S_COLLECT) && w_match;
  assign w_busy  = (r_state == S_DRAIN) || (r_state == S_DONE);
  assign w_load  = start && ((r_state == S_IDLE) ||
                   ((r_state == S_DONE) && result_ack));

  always_comb begin
    w_kk = 6'd1;
    unique case (image_padding)
      2'd0: w_kk = 6'd1;
      2'd1: w_kk = 6'd9;
      2'd2: w_kk = 6'd25;
      2'd3: w_kk = 6'd49;
    endcase
  end

  assign w_last = 15'(w_kk) * (15'(z_max) + 15'd1) - 15'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_px   <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_tap  <= '0;
    end else begin
      r_v1 <= w_take;
      r_v2 <= r_v1;
      if (w_take) begin
        r_px  <= issue_data;
        r_tap <= r_tap + 15'd1;
      end
      if (r_v1)
        r_prod <= 36'(r_px) * 36'(weight_data);
      if (w_load) begin
        r_acc <= '0;
        r_tap <= '0;
      end else if (r_v2) begin
        r_acc <= r_acc + ACC_W'(r_prod);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= '0;
      r_ty    <= '0;
      r_p     <= '0;
      r_last  <= '0;
      r_valid <= 1'b0;
      r_block <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_busy && w_match)
        r_ovf <= 1'b1;
      if (w_load) begin
        r_tx   <= target_x;
        r_ty   <= target_y;
        r_p    <= image_padding;
        r_last <= w_last;
        r_ovf  <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start)
            r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (w_take && (r_tap == r_last)) begin
            r_state <= S_DRAIN;
            r_block <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Final add lands on the same edge that enters DONE.
          if (!r_v1) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (result_ack) begin
            r_valid <= 1'b0;
            r_block <= 1'b0;
            r_state <= start ? S_COLLECT : S_IDLE;
          end
        end
      endcase
    end
  end

  assign weight_addr  = r_tap[11:0];
  assign result       = r_acc;
  assign result_valid = r_valid;
  assign alloc_block  = r_block;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_window_allocator.sv
// Directed bench for window_allocator with a transaction-level model
// checked on every cycle plus hand-computed literal expectations.
module tb_window_allocator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [7:0]         target_x;
  logic [7:0]         target_y;
  logic [1:0]         image_padding;
  logic [8:0]         z_max;
  logic               issue_en;
  logic [7:0]         issue_x;
  logic [7:0]         issue_y;
  logic signed [17:0] issue_data;
  logic [11:0]        weight_addr;
  logic signed [17:0] weight_data;
  logic               alloc_block;
  logic signed [39:0] result;
  logic               result_valid;
  logic               result_ack;
  logic               overflow;

  window_allocator #(.ACC_W(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .target_x     (target_x),
    .target_y     (target_y),
    .image_padding(image_padding),
    .z_max        (z_max),
    .issue_en     (issue_en),
    .issue_x      (issue_x),
    .issue_y      (issue_y),
    .issue_data   (issue_data),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .alloc_block  (alloc_block),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  logic [17:0] wmem [0:4095];
  always @(posedge clk) weight_data <= wmem[weight_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: window membership, tap order and timing from the rules only.
  bit     chk_en = 0;
  int     m_cyc = 0;
  int     m_phase = 0;
  int     m_tx, m_ty, m_p, m_total;
  int     m_taken = 0;
  int     m_fin = 0;
  longint m_sum = 0;
  bit     m_ovf = 0;

  task automatic m_load();
    m_tx    = int'(target_x);
    m_ty    = int'(target_y);
    m_p     = int'(image_padding);
    m_total = (2 * m_p + 1) * (2 * m_p + 1) * (int'(z_max) + 1);
    m_taken = 0;
    m_sum   = 0;
    m_ovf   = 0;
    m_phase = 1;
  endtask

  always @(posedge clk) begin
    bit match;
    int ix, iy;
    m_cyc++;
    if (rst) begin
      m_phase = 0;
      m_taken = 0;
      m_sum   = 0;
      m_ovf   = 0;
      chk_en  = 1;
    end else begin
      ix = int'(issue_x);
      iy = int'(issue_y);
      match = issue_en && ix >= m_tx - m_p && ix <= m_tx + m_p &&
              iy >= m_ty - m_p && iy <= m_ty + m_p;
      case (m_phase)
        0: if (start) m_load();
        1: if (match) begin
          m_sum += longint'($signed(issue_data)) *
                   longint'($signed(wmem[m_taken]));
          m_taken++;
          if (m_taken == m_total) begin
            m_phase = 2;
            m_fin   = m_cyc;
          end
        end
        default: begin
          if (match) m_ovf = 1;
          if (result_ack && m_cyc >= m_fin + 3) begin
            if (start) m_load();
            else m_phase = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit          e_rv;
    logic [39:0] e_res;
    if (chk_en) begin
      e_rv  = (m_phase == 2) && (m_cyc >= m_fin + 2);
      e_res = m_sum[39:0];
      chk("m_addr", 64'(weight_addr), 64'(m_taken % 4096));
      chk("m_valid", 64'(result_valid), 64'(e_rv));
      chk("m_block", 64'(alloc_block), 64'(m_phase == 2));
      chk("m_ovf", 64'(overflow), 64'(m_ovf));
      if (e_rv)
        chk("m_result", {24'b0, result}, {24'b0, e_res});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pix(input int x, input int y, input int d);
    issue_en   = 1'b1;
    issue_x    = 8'(x);
    issue_y    = 8'(y);
    issue_data = 18'(d);
    @(negedge clk);
    issue_en   = 1'b0;
  endtask

  task automatic go(input int x, input int y, input int p, input int z,
                    input bit ack);
    start         = 1'b1;
    result_ack    = ack;
    target_x      = 8'(x);
    target_y      = 8'(y);
    image_padding = 2'(p);
    z_max         = 9'(z);
    @(negedge clk);
    start         = 1'b0;
    result_ack    = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rv_timeout", 64'(result_valid), 64'(1));
  endtask

  task automatic ones3x3();
    for (int y = 4; y <= 6; y++)
      for (int x = 4; x <= 6; x++)
        pix(x, y, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result_ack = 1'b0;
    target_x = '0; target_y = '0; image_padding = '0; z_max = '0;
    issue_en = 1'b0; issue_x = '0; issue_y = '0; issue_data = '0;
    for (int i = 0; i < 4096; i++) wmem[i] = '0;
    repeat (2) tick();
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_valid", 64'(result_valid), 64'(0));
    chk("rst_block", 64'(alloc_block), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_addr", 64'(weight_addr), 64'(0));
    rst = 1'b0;
    tick();

    // 3x3 window of ones
    for (int i = 0; i < 9; i++) wmem[i] = 18'd1;
    go(5, 5, 1, 0, 0);
    chk("s1_addr0", 64'(weight_addr), 64'(0));
    ones3x3();
    chk("s1_rv_c1", 64'(result_valid), 64'(0));
    tick();
    chk("s1_rv_c2", 64'(result_valid), 64'(0));
    tick();
    chk("s1_rv_c3", 64'(result_valid), 64'(1));
    chk("s1_result", 64'($signed(result)), 64'(9));
    chk("s1_model", 64'(m_sum), 64'(9));
    chk("s1_addr", 64'(weight_addr), 64'(9));

    // hold in DONE with a stray matching pixel
    for (int i = 0; i < 10; i++)
      if (i == 4) pix(5, 5, 7);
      else tick();
    chk("hold_result", 64'($signed(result)), 64'(9));
    chk("hold_ovf", 64'(overflow), 64'(1));
    chk("hold_block", 64'(alloc_block), 64'(1));
    ack();
    chk("ack_valid", 64'(result_valid), 64'(0));
    chk("ack_block", 64'(alloc_block), 64'(0));

    // 5x5, two channels, with out-of-window x=5 interleaved
    for (int i = 0; i < 50; i++) wmem[i] = 18'd3;
    go(2, 2, 2, 1, 0);
    chk("s2_ovf_clr", 64'(overflow), 64'(0));
    for (int z = 0; z < 2; z++)
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 6; x++) pix(x, y, -2);
        if (z == 0 && y == 0)
          chk("s2_addr_row0", 64'(weight_addr), 64'(5));
      end
    wait_rv();
    chk("s2_result", 64'($signed(result)), 64'(-300));
    chk("s2_model", 64'(m_sum), 64'(-300));
    ack();

    // 1x1, three channels, at the image corner
    wmem[0] = 18'd1; wmem[1] = 18'd2; wmem[2] = 18'd3;
    go(0, 0, 0, 2, 0);
    pix(255, 0, 99);
    pix(0, 255, 99);
    chk("s3_nomatch", 64'(weight_addr), 64'(0));
    pix(0, 0, 4);
    pix(0, 0, 5);
    pix(0, 0, 6);
    wait_rv();
    chk("s3_result", 64'($signed(result)), 64'(32));
    pix(0, 0, 1);
    chk("s3_ovf", 64'(overflow), 64'(1));

    // start together with ack
    for (int i = 0; i < 9; i++) wmem[i] = 18'd1;
    go(5, 5, 1, 0, 1);
    chk("sa_valid", 64'(result_valid), 64'(0));
    chk("sa_ovf", 64'(overflow), 64'(0));
    chk("sa_addr", 64'(weight_addr), 64'(0));
    ones3x3();
    wait_rv();
    chk("sa_result", 64'($signed(result)), 64'(9));
    ack();

    // reset mid-collection
    go(5, 5, 1, 0, 0);
    for (int x = 4; x <= 6; x++) pix(x, 4, 1);
    pix(4, 5, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_addr", 64'(weight_addr), 64'(0));
    repeat (6) tick();
    chk("r_valid", 64'(result_valid), 64'(0));
    go(5, 5, 1, 0, 0);
    ones3x3();
    wait_rv();
    chk("r_result", 64'($signed(result)), 64'(9));
    ack();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/window_allocator.md
WINDOW_ALLOCATOR -- requirements
Module: window_allocator

Interface
REQ-001 SHALL have parameter ACC_W, default 40, signed accumulator/result width.
REQ-002 SHALL have ports, in this order:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches the window description below.
- target_x  input  8  window centre column, padded coordinates.
- target_y  input  8  window centre row, padded coordinates.
- image_padding  input  2  P; filter is K=2P+1 (1x1/3x3/5x5); 3 is illegal.
- z_max  input  9  last channel index.
- issue_en  input  1  broadcast pixel valid.
- issue_x  input  8  broadcast pixel column.
- issue_y  input  8  broadcast pixel row.
- issue_data  input  18  broadcast pixel value, signed.
- weight_addr  output  12  filter weight RAM address.
- weight_data  input  18  signed weight; registered RAM, valid 1 cycle after weight_addr.
- alloc_block  output  1  stall request, ORed upstream into the broadcast block input.
- result  output  ACC_W  signed dot product.
- result_valid  output  1  result holds a finished sum.
- result_ack  input  1  consumer accepts result.
- overflow  output  1  sticky: a matching pixel was dropped.

Function
REQ-003 SHALL implement states IDLE, COLLECT, DRAIN, DONE.
REQ-004 SHALL, in IDLE, ignore issue_en; on start, latch target_x, target_y, P, z_max, clear accumulator, tap counter, overflow; go COLLECT.
REQ-005 SHALL, in COLLECT, treat a pixel as matching when issue_en=1 and target_x-P <= issue_x <= target_x+P and target_y-P <= issue_y <= target_y+P; compare at 9 bits so target_x<P does not wrap.
REQ-006 SHALL drive weight_addr from a running tap counter (0 at start, +1 per matching pixel), i.e. z*K*K + row*K + col for in-order raster arrival.
REQ-007 SHALL pipeline: cycle 0 match, present weight_addr, register pixel; cycle 1 multiply 18x18 signed to 36 bits; cycle 2 sign-extend and add into accumulator.
REQ-008 SHALL, when the matching pixel with tap counter = K*K*(z_max+1)-1 is taken, go DRAIN.
REQ-009 SHALL, in DRAIN, take no new pixels, wait until the pipeline is empty, then go DONE.
REQ-010 SHALL assert result_valid and hold result stable in DONE; result_valid rises exactly 3 cycles after the last matching issue_en cycle.
REQ-011 SHALL assert alloc_block in DRAIN and DONE, and only there.
REQ-012 SHALL, when a matching pixel arrives in DRAIN or DONE, drop it and set overflow until next start or rst.
REQ-013 SHALL, on result_ack in DONE, deassert result_valid next cycle and go IDLE; result_ack outside DONE is ignored.
REQ-014 SHALL, on start in the same cycle as result_ack in DONE, perform both: accept the ack and load the new window, going COLLECT.
REQ-015 SHALL ignore start in COLLECT and DRAIN.
REQ-016 SHALL wrap the accumulator modulo 2^ACC_W, no saturation.
REQ-017 SHALL accept issue_data as received; zero-padding values count as normal taps.

Reset
REQ-018 SHALL, on rst, go IDLE, clear pipeline valids, and drive result=0, result_valid=0, alloc_block=0, overflow=0, weight_addr=0.
REQ-019 SHALL, on rst mid-COLLECT or DRAIN, discard the partial sum; no result_valid follows.

Verification
REQ-020 3x3 (P=1), target (5,5), z_max=0, raster stream x,y 4..6, all data=1, weights=1 -> result=9, result_valid 3 cycles after pixel (6,6), weight_addr 0..8.
REQ-021 5x5 (P=2), target (2,2), z_max=1, 50 taps, data=-2, weights=3 -> result=-300; non-matching pixels (x=5) never advance weight_addr.
REQ-022 P=0, target (0,0), z_max=2, data 4,5,6, weights 1,2,3 -> result=32; nothing matches with x=255.
REQ-023 Result held 10 cycles with matching pixel injected in DONE -> result unchanged, overflow=1, alloc_block=1; result_ack -> IDLE next cycle.
REQ-024 rst after 4 of 9 taps, then new 3x3 start with all 1s -> result=9, no earlier result_valid.
REQ-025 start same cycle as result_ack -> result_valid drops, new window collected, overflow cleared.
